// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared definitions for the button conditioner: FSM state
//               encodings and the millisecond-to-cycle conversion helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    // Press-tracking FSM states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        ST_REL    = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_t;

    localparam int unsigned c_MS_PER_S = 1000;

    // Converts a duration in milliseconds into clock cycles
    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return (clk_freq / c_MS_PER_S) * ms;
    endfunction

    // Bits needed for a counter that must be able to hold max_count
    function automatic int cnt_width(input int unsigned max_count);
        return (max_count == 0) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer bringing an asynchronous single-bit
//               input into the clk domain. Asynchronous active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back captures give the first stage a full cycle to resolve
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronizes and debounces a raw pushbutton, then produces
//               one-cycle press / release / long-press / auto-repeat ticks.
//               Optional feature macro: BTN_AUTOREPEAT_EN (enables the
//               REPEAT state and repeat_tick; otherwise repeat_tick is 0).
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int unsigned CLK_FREQ    = 100_000_000,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000,
    parameter int unsigned REPEAT_MS   = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic level,
    output logic press_tick,
    output logic release_tick,
    output logic long_tick,
    output logic repeat_tick
);

    import btn_pkg::*;

    localparam int unsigned c_DB_CYC   = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned c_LONG_CYC = ms_to_cycles(CLK_FREQ, LONG_MS);
    localparam int unsigned c_REP_CYC  = ms_to_cycles(CLK_FREQ, REPEAT_MS);

    localparam int unsigned c_MAX_CYC =
        (c_DB_CYC > c_LONG_CYC) ? ((c_DB_CYC   > c_REP_CYC) ? c_DB_CYC   : c_REP_CYC)
                                : ((c_LONG_CYC > c_REP_CYC) ? c_LONG_CYC : c_REP_CYC);

    localparam int c_CNT_W = cnt_width(c_MAX_CYC);

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_DB_TERM   = c_CNT_W'(c_DB_CYC);
    localparam logic [c_CNT_W-1:0] c_LONG_LAST = c_CNT_W'(c_LONG_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_LONG_DONE = c_CNT_W'(c_LONG_CYC);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [c_CNT_W-1:0] c_REP_LAST  = c_CNT_W'(c_REP_CYC - 1);
`endif

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic w_btn_sync;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (button_in),
        .q     (w_btn_sync)
    );

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    logic               r_level;
    logic [c_CNT_W-1:0] r_db_cnt;
    logic               w_differs;
    logic               w_db_done;
    logic               w_press_evt;
    logic               w_release_evt;

    assign w_differs     = (w_btn_sync != r_level);
    // The counter reaching DB_CYC while the input still disagrees commits the
    // new level, which places the level change 2+DB_CYC cycles after the input.
    assign w_db_done     = w_differs && (r_db_cnt == c_DB_TERM);
    assign w_press_evt   = w_db_done && !r_level;
    assign w_release_evt = w_db_done &&  r_level;

    // Count consecutive cycles of disagreement; any agreement restarts it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_db_cnt <= '0;
            r_level  <= 1'b0;
        end else if (!w_differs) begin
            r_db_cnt <= '0;
        end else if (w_db_done) begin
            r_db_cnt <= '0;
            r_level  <= w_btn_sync;
        end else begin
            r_db_cnt <= r_db_cnt + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Press-tracking FSM
    // ------------------------------------------------------------------
    btn_state_t         r_state;
    btn_state_t         w_state_nxt;
    logic [c_CNT_W-1:0] r_hold_cnt;
    logic [c_CNT_W-1:0] w_hold_nxt;
    logic               w_long_nxt;
    logic               r_press_tick;
    logic               r_release_tick;
    logic               r_long_tick;
`ifdef BTN_AUTOREPEAT_EN
    logic [c_CNT_W-1:0] r_rep_cnt;
    logic [c_CNT_W-1:0] w_rep_cnt_nxt;
    logic               w_rep_nxt;
    logic               r_repeat_tick;
`endif

    // Next state, counters and tick requests; a release overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_long_nxt    = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        w_rep_cnt_nxt = r_rep_cnt;
        w_rep_nxt     = 1'b0;
`endif
        if (w_release_evt) begin
            // Any long/repeat tick due this cycle is dropped in favour of release
            w_state_nxt   = ST_REL;
            w_hold_nxt    = '0;
`ifdef BTN_AUTOREPEAT_EN
            w_rep_cnt_nxt = '0;
`endif
        end else begin
            case (r_state)
                ST_REL: begin
                    w_hold_nxt = '0;
                    if (w_press_evt) begin
                        w_state_nxt = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (r_hold_cnt == c_LONG_LAST) begin
                        w_long_nxt = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        w_state_nxt   = ST_REPEAT;
                        w_hold_nxt    = '0;
                        w_rep_cnt_nxt = '0;
`else
                        // Park past the terminal value so long_tick fires once
                        w_hold_nxt = c_LONG_DONE;
`endif
                    end else if (r_hold_cnt != c_LONG_DONE) begin
                        w_hold_nxt = r_hold_cnt + c_CNT_ONE;
                    end
                end
                ST_REPEAT: begin
`ifdef BTN_AUTOREPEAT_EN
                    // Counter never runs past its terminal value; each tick
                    // restarts the period so an endless hold keeps ticking.
                    if (r_rep_cnt >= c_REP_LAST) begin
                        w_rep_nxt     = 1'b1;
                        w_rep_cnt_nxt = '0;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + c_CNT_ONE;
                    end
`else
                    w_state_nxt = ST_REL;
                    w_hold_nxt  = '0;
`endif
                end
                default: begin
                    w_state_nxt = ST_REL;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // State, counters and registered single-cycle ticks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_REL;
            r_hold_cnt     <= '0;
            r_press_tick   <= 1'b0;
            r_release_tick <= 1'b0;
            r_long_tick    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt      <= '0;
            r_repeat_tick  <= 1'b0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_press_tick   <= w_press_evt;
            r_release_tick <= w_release_evt;
            r_long_tick    <= w_long_nxt;
`ifdef BTN_AUTOREPEAT_EN
            r_rep_cnt      <= w_rep_cnt_nxt;
            r_repeat_tick  <= w_rep_nxt;
`endif
        end
    end

    assign level        = r_level;
    assign press_tick   = r_press_tick;
    assign release_tick = r_release_tick;
    assign long_tick    = r_long_tick;
`ifdef BTN_AUTOREPEAT_EN
    assign repeat_tick  = r_repeat_tick;
`else
    assign repeat_tick  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Self-checking bench for button_conditioner at 1 kHz so that
//               1 ms equals 1 clock cycle. Directed scenarios plus random
//               stimulus compared against a window/arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    localparam int unsigned CLK_FREQ    = 1000;
    localparam int unsigned DEBOUNCE_MS = 4;
    localparam int unsigned LONG_MS     = 20;
    localparam int unsigned REPEAT_MS   = 5;

    localparam int DB   = int'(CLK_FREQ / 1000 * DEBOUNCE_MS);
    localparam int LONG = int'(CLK_FREQ / 1000 * LONG_MS);
    localparam int REP  = int'(CLK_FREQ / 1000 * REPEAT_MS);
    localparam int RAW_DEPTH = 8192;

`ifdef BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic button_in = 1'b0;
    logic level, press_tick, release_tick, long_tick, repeat_tick;
    logic [4:0] obs;

    assign obs = {level, press_tick, release_tick, long_tick, repeat_tick};

    button_conditioner #(
        .CLK_FREQ    (CLK_FREQ),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS),
        .REPEAT_MS   (REPEAT_MS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_in    (button_in),
        .level        (level),
        .press_tick   (press_tick),
        .release_tick (release_tick),
        .long_tick    (long_tick),
        .repeat_tick  (repeat_tick)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit raw [0:RAW_DEPTH-1];
    int edge_no      = 0;
    int first_ok     = 0;
    bit m_level      = 1'b0;
    bit m_press      = 1'b0;
    bit m_rel        = 1'b0;
    bit m_long       = 1'b0;
    bit m_rep        = 1'b0;
    int m_press_edge = -1;

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [4:0] model_vec();
        return {m_level, m_press, m_rel, m_long, m_rep};
    endfunction

    // Advance one rising edge and update the model for it. The level flips
    // once the sample seen two edges late has disagreed with it on DB+1
    // consecutive post-reset edges; ticks are scheduled arithmetically from
    // the press edge.
    task automatic step();
        int k;
        int d;
        bit flip;
        @(posedge clk);
        k = edge_no;
        edge_no++;
        if (k >= RAW_DEPTH) begin
            $display("FAIL model_depth edge=%0d limit=%0d", k, RAW_DEPTH);
            $fatal(1);
        end
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        m_rep   = 1'b0;
        if (!reset) begin
            raw[k]       = 1'b0;
            first_ok     = k + 1;
            m_level      = 1'b0;
            m_press_edge = -1;
        end else begin
            raw[k] = button_in;
            flip = (k - DB >= first_ok) && (k - DB >= 2);
            for (int j = k - DB; j <= k; j++) begin
                if (flip && (raw[j-2] == m_level)) flip = 1'b0;
            end
            if (flip) begin
                m_level = !m_level;
                if (m_level) begin
                    m_press      = 1'b1;
                    m_press_edge = k;
                end else begin
                    m_rel        = 1'b1;
                    m_press_edge = -1;
                end
            end else if (m_level && m_press_edge >= 0) begin
                d = k - m_press_edge;
                m_long = (d == LONG);
                m_rep  = AUTOREP && (d > LONG) && (((d - LONG) % REP) == 0);
            end
        end
        #1;
    endtask

    task automatic settle(input int n);
        @(negedge clk);
        button_in = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        button_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            vectors++;
            if (obs !== 5'b0) begin
                miscompares++;
                $display("FAIL reset_state cyc=%0d got=%b want=%b", c, obs, 5'b0);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            step();
            vectors++;
            if (obs !== model_vec() || press_tick !== (c == 6)) begin
                miscompares++;
                $display("FAIL reset_release_press cyc=%0d got=%b want=%b press_at=6",
                         c, obs, model_vec());
            end
        end
        settle(12);
    endtask

    task automatic test_long_hold();
        logic [2:0] exp;
        @(negedge clk);
        button_in = 1'b1;
        for (int c = 0; c < 46; c++) begin
            step();
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL hold_model cyc=%0d got=%b want=%b", c, obs, model_vec());
            end
            exp = {c == 6, c == 26, AUTOREP && (c == 31 || c == 36 || c == 41)};
            vectors++;
            if ({press_tick, long_tick, repeat_tick} !== exp) begin
                miscompares++;
                $display("FAIL hold_schedule cyc=%0d got=%b want=%b",
                         c, {press_tick, long_tick, repeat_tick}, exp);
            end
        end
        settle(14);
    endtask

    task automatic test_glitch();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            button_in = (c < 3);
            step();
            vectors++;
            if (obs !== 5'b0 || obs !== model_vec()) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", c, obs, 5'b0);
            end
        end
    endtask

    task automatic test_bounce();
        int presses = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            button_in = (c < 10) ? (((c / 2) % 2) == 0) : 1'b1;
            step();
            if (press_tick === 1'b1) presses++;
            vectors++;
            if (obs !== model_vec() || press_tick !== (c == 14) || level !== (c >= 14)) begin
                miscompares++;
                $display("FAIL bounce cyc=%0d got=%b want=%b press_at=14",
                         c, obs, model_vec());
            end
        end
        vectors++;
        if (presses != 1) begin
            miscompares++;
            $display("FAIL bounce_count got=%0d want=1", presses);
        end
        settle(14);
    endtask

    task automatic test_release_on_repeat();
        int drop;
        int rel_at;
        drop   = AUTOREP ? 25 : 20;
        rel_at = drop + 2 + DB;
        for (int c = 0; c < 41; c++) begin
            @(negedge clk);
            button_in = (c < drop);
            step();
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL coincide_model cyc=%0d got=%b want=%b", c, obs, model_vec());
            end
            if (c == rel_at) begin
                vectors++;
                if (obs !== 5'b00100) begin
                    miscompares++;
                    $display("FAIL coincide_release cyc=%0d got=%b want=%b", c, obs, 5'b00100);
                end
            end else if (c > rel_at) begin
                vectors++;
                if (obs !== 5'b0) begin
                    miscompares++;
                    $display("FAIL coincide_after cyc=%0d got=%b want=%b", c, obs, 5'b0);
                end
            end
        end
        // A fresh press must start cleanly from the released state
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            button_in = 1'b1;
            step();
            vectors++;
            if (obs !== model_vec() || press_tick !== (c == 6) || long_tick !== (c == 26)) begin
                miscompares++;
                $display("FAIL coincide_repress cyc=%0d got=%b want=%b", c, obs, model_vec());
            end
        end
        settle(14);
    endtask

    task automatic test_reset_mid_hold();
        for (int c = 0; c < 33; c++) begin
            @(negedge clk);
            button_in = 1'b1;
            if (c == 16) begin
                reset = 1'b0;
                #1;
                vectors++;
                if (obs !== 5'b0) begin
                    miscompares++;
                    $display("FAIL reset_async_clear got=%b want=%b", obs, 5'b0);
                end
            end
            if (c == 18) reset = 1'b1;
            step();
            vectors++;
            if (obs !== model_vec() || release_tick !== 1'b0 ||
                press_tick !== (c == 6 || c == 24)) begin
                miscompares++;
                $display("FAIL reset_mid_hold cyc=%0d got=%b want=%b", c, obs, model_vec());
            end
            if (c == 16 || c == 17) begin
                vectors++;
                if (obs !== 5'b0) begin
                    miscompares++;
                    $display("FAIL reset_hold_zero cyc=%0d got=%b want=%b", c, obs, 5'b0);
                end
            end
        end
        settle(14);
    endtask

    task automatic test_random();
        int run      = 0;
        int rst_left = 0;
        bit val      = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (reset == 1'b0) begin
                rst_left--;
                if (rst_left <= 0) reset = 1'b1;
            end else if ($urandom_range(0, 199) == 0) begin
                reset    = 1'b0;
                rst_left = int'($urandom_range(2, 4));
            end
            if (run == 0) begin
                val = !val;
                run = ($urandom_range(0, 4) == 0) ? int'($urandom_range(20, 70))
                                                  : int'($urandom_range(1, 10));
            end
            run--;
            button_in = val;
            step();
            vectors++;
            if (obs !== model_vec()) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b want=%b", c, obs, model_vec());
            end
            vectors++;
            if ($countones({press_tick, release_tick, long_tick, repeat_tick}) > 1) begin
                miscompares++;
                $display("FAIL random_onehot cyc=%0d got=%b want=at_most_one_tick",
                         c, obs[3:0]);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        settle(14);
    endtask

    initial begin
        test_reset();
        test_long_hold();
        test_glitch();
        test_bounce();
        test_release_on_repeat();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time=%0t limit=400000", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
